// File: rtl/ushift_seq.sv
// Sequential shift/rotate unit: one bit per clock, multi-bit amount,
// five shift/rotate modes, start/busy/done handshake, carry and zero flags.
//
// Handshake: start is accepted on a rising edge only while busy=0. busy is
// high from the edge after accept until the edge that raises done; done is
// a one-cycle pulse in the first IDLE cycle. A start seen in the done cycle
// is accepted normally. result and carry hold after done until the next
// accept or reset.
module ushift_seq #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [AMT_W-1:0] amt,
    input  logic [WIDTH-1:0] a,
    input  logic             bsLeft,
    input  logic             bsRight,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done,
    output logic             carry,
    output logic             zero
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    localparam logic [2:0] OP_LSL = 3'b000;
    localparam logic [2:0] OP_LSR = 3'b001;
    localparam logic [2:0] OP_ASR = 3'b010;
    localparam logic [2:0] OP_ROL = 3'b011;
    localparam logic [2:0] OP_ROR = 3'b100;

    logic [0:0]       state;
    logic [AMT_W-1:0] count;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] result_q;
    logic             carry_q;
    logic             done_q;

    // Control FSM plus the shift datapath; one bit moves per SHIFT cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            count    <= '0;
            op_q     <= OP_LSL;
            result_q <= '0;
            carry_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        result_q <= a;
                        count    <= amt;
                        op_q     <= op;
                        carry_q  <= 1'b0;
                        state    <= ST_SHIFT;
                    end
                end
                default: begin
                    if (count != '0) begin
                        // Reserved ops leave data untouched but still consume
                        // the same number of cycles as a real shift.
                        case (op_q)
                            OP_LSL: begin
                                result_q <= {result_q[WIDTH-2:0], bsLeft};
                                carry_q  <= result_q[WIDTH-1];
                            end
                            OP_LSR: begin
                                result_q <= {bsRight, result_q[WIDTH-1:1]};
                                carry_q  <= result_q[0];
                            end
                            OP_ASR: begin
                                result_q <= {result_q[WIDTH-1], result_q[WIDTH-1:1]};
                                carry_q  <= result_q[0];
                            end
                            OP_ROL: begin
                                result_q <= {result_q[WIDTH-2:0], result_q[WIDTH-1]};
                                carry_q  <= result_q[WIDTH-1];
                            end
                            OP_ROR: begin
                                result_q <= {result_q[0], result_q[WIDTH-1:1]};
                                carry_q  <= result_q[0];
                            end
                            default: begin
                                result_q <= result_q;
                                carry_q  <= carry_q;
                            end
                        endcase
                        count <= count - AMT_W'(1);
                    end else begin
                        state  <= ST_IDLE;
                        done_q <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign result = result_q;
    assign carry  = carry_q;
    assign done   = done_q;
    assign busy   = (state == ST_SHIFT);
    assign zero   = (result_q == '0);

endmodule

// File: tb/tb_ushift_seq.sv
// Directed bench for ushift_seq: drivers push expected {latency, carry,
// result} into a queue on accept; a negedge monitor pops on done and checks.
module tb_ushift_seq;

    localparam int W  = 8;
    localparam int AW = 4;
    localparam int EW = 8 + 1 + W;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [2:0]    op = 3'b000;
    logic [AW-1:0] amt = '0;
    logic [W-1:0]  a = '0;
    logic          bsLeft = 1'b0;
    logic          bsRight = 1'b0;
    logic [W-1:0]  result;
    logic          busy;
    logic          done;
    logic          carry;
    logic          zero;

    logic [EW-1:0] exp_q[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int accept_cyc = 0;
    int busy_cnt = 0;

    ushift_seq #(.WIDTH(W), .AMT_W(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .amt(amt), .a(a),
        .bsLeft(bsLeft), .bsRight(bsRight), .result(result), .busy(busy),
        .done(done), .carry(carry), .zero(zero)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: counts busy cycles, and on done pops and compares
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (reset) begin
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("result", 32'(result), 32'(e[W-1:0]));
                    check("carry", 32'(carry), 32'(e[W]));
                    check("zero", 32'(zero), 32'(e[W-1:0] == '0));
                    check("latency", 32'(cyc - accept_cyc), 32'(e[EW-1:W+1]));
                    check("busy_cycles", 32'(busy_cnt), 32'(e[EW-1:W+1]));
                end
                busy_cnt = 0;
            end
        end
    end

    // Driver: present an op, accept on next posedge, optionally push expected
    task automatic issue(input logic [2:0] o, input logic [AW-1:0] n, input logic [W-1:0] d,
                         input logic bl, input logic br, input logic [W-1:0] er,
                         input logic ec, input logic push);
        op = o; amt = n; a = d; bsLeft = bl; bsRight = br; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        accept_cyc = cyc;
        if (push) exp_q.push_back({8'(32'(n) + 1), ec, er});
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 32'(exp_q.size()), 32'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_result"}, 32'(result), 32'(0));
        check({tag, "_carry"}, 32'(carry), 32'(0));
        check({tag, "_busy"}, 32'(busy), 32'(0));
        check({tag, "_done"}, 32'(done), 32'(0));
        check({tag, "_zero"}, 32'(zero), 32'(1));
    endtask

    initial begin
        int n;
        // Reset for two cycles, then idle with start low
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_idle("post_reset");
        end
        @(posedge clk); #1;

        // LSL 10110011 by 3, fill 1
        issue(3'b000, 4'd3, 8'b10110011, 1'b1, 1'b0, 8'b10011111, 1'b1, 1'b1);
        drain();
        // ASR 10010000 by 2
        issue(3'b010, 4'd2, 8'b10010000, 1'b0, 1'b0, 8'b11100100, 1'b0, 1'b1);
        drain();
        // LSR same operand, fill 0
        issue(3'b001, 4'd2, 8'b10010000, 1'b0, 1'b0, 8'b00100100, 1'b0, 1'b1);
        drain();
        // ROR by 9 wraps
        issue(3'b100, 4'd9, 8'b00000001, 1'b0, 1'b0, 8'b10000000, 1'b1, 1'b1);
        drain();
        // amt=0 passes the operand through
        issue(3'b000, 4'd0, 8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1);
        drain();
        // LSL by full width clears the word
        issue(3'b000, 4'd8, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        drain();
        // Reserved op: unchanged data, same timing
        issue(3'b101, 4'd3, 8'h5A, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1);
        drain();

        // start while busy is ignored
        issue(3'b011, 4'd3, 8'h81, 1'b0, 1'b0, 8'h0C, 1'b0, 1'b1);
        @(posedge clk); #1;
        op = 3'b001; amt = 4'd0; a = 8'hFF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        drain();

        // bsRight changes between steps
        issue(3'b001, 4'd2, 8'h00, 1'b0, 1'b1, 8'h40, 1'b0, 1'b1);
        @(posedge clk); #1;
        bsRight = 1'b0;
        drain();

        // Back-to-back: start presented in the done cycle
        issue(3'b100, 4'd1, 8'h03, 1'b0, 1'b0, 8'h81, 1'b1, 1'b1);
        n = 0;
        @(negedge clk);
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("b2b_done_seen", 32'(done), 32'(1));
        issue(3'b001, 4'd4, 8'hF0, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b1);
        drain();

        // Reset on the 2nd SHIFT cycle of ROL by 5 aborts without done
        issue(3'b011, 4'd5, 8'h81, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_idle("abort");
        repeat (8) @(negedge clk);
        @(posedge clk); #1;

        // Following start accepted normally
        issue(3'b000, 4'd1, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time limit
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
